// File: rtl/bus_if.sv
// Bus-block signal bundle: source selects, load enables, ALU control, memory
// data in, and every register/bus value the block exposes.
// The master side (datapath controller or bench) drives the controls; the
// slave side (the bus block) drives the register contents and the bus value.
interface bus_if;
  logic        R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out;
  logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out;
  logic        HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout;
  logic        R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in;
  logic        R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in;
  logic        HIin, LOin, Zin, Yin, MDRin;
  logic [11:0] ALUControl;
  logic [31:0] Mdatain;
  logic        MDRRead;
  logic [31:0] BusMuxOut;
  logic [31:0] R0MuxIn, R1MuxIn, R2MuxIn, R3MuxIn, R4MuxIn, R5MuxIn, R6MuxIn, R7MuxIn;
  logic [31:0] R8MuxIn, R9MuxIn, R10MuxIn, R11MuxIn, R12MuxIn, R13MuxIn, R14MuxIn, R15MuxIn;
  logic [31:0] HIMuxIn, LOMuxIn, ZhighMuxIn, ZlowMuxIn, PCMuxIn, MDRMuxIn, InPortMuxIn, CMuxIn;
  logic [31:0] Yout;

  modport master (
    output R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
           R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
           HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout,
           R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
           R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
           HIin, LOin, Zin, Yin, MDRin, ALUControl, Mdatain, MDRRead,
    input  BusMuxOut,
           R0MuxIn, R1MuxIn, R2MuxIn, R3MuxIn, R4MuxIn, R5MuxIn, R6MuxIn, R7MuxIn,
           R8MuxIn, R9MuxIn, R10MuxIn, R11MuxIn, R12MuxIn, R13MuxIn, R14MuxIn, R15MuxIn,
           HIMuxIn, LOMuxIn, ZhighMuxIn, ZlowMuxIn, PCMuxIn, MDRMuxIn, InPortMuxIn, CMuxIn,
           Yout
  );

  modport slave (
    input  R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
           R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
           HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout,
           R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
           R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
           HIin, LOin, Zin, Yin, MDRin, ALUControl, Mdatain, MDRRead,
    output BusMuxOut,
           R0MuxIn, R1MuxIn, R2MuxIn, R3MuxIn, R4MuxIn, R5MuxIn, R6MuxIn, R7MuxIn,
           R8MuxIn, R9MuxIn, R10MuxIn, R11MuxIn, R12MuxIn, R13MuxIn, R14MuxIn, R15MuxIn,
           HIMuxIn, LOMuxIn, ZhighMuxIn, ZlowMuxIn, PCMuxIn, MDRMuxIn, InPortMuxIn, CMuxIn,
           Yout
  );
endinterface

// File: rtl/bus.sv
// Single-bus datapath: 16 GPRs, HI/LO, Y, Z (64-bit), MDR, plus PC/InPort/C
// placeholders, a priority-encoded shared bus and a one-hot controlled ALU
// (A = Y, B = bus). Z captures the ALU result, so it appears one cycle later.
// Optional macro BUS_MULDIV_EN enables the signed multiplier and divider;
// without it MUL and DIV produce zero.
module bus (
  input  logic clk,
  input  logic clr,
  bus_if.slave bi
);

  logic [15:0] rOut;
  logic [15:0] rIn;
  logic [31:0] r_q [16];
  logic [31:0] hi_q, lo_q, y_q, mdr_q, zhi_q, zlo_q;
  logic [31:0] pc_q, inport_q, c_q;
  logic [31:0] mdr_d;
  logic [31:0] busMux;
  logic [63:0] aluResult;
  logic [4:0]  shAmt;
  logic [5:0]  rotAmt;

  assign rOut = {bi.R15out, bi.R14out, bi.R13out, bi.R12out, bi.R11out, bi.R10out,
                 bi.R9out, bi.R8out, bi.R7out, bi.R6out, bi.R5out, bi.R4out,
                 bi.R3out, bi.R2out, bi.R1out, bi.R0out};
  assign rIn  = {bi.R15in, bi.R14in, bi.R13in, bi.R12in, bi.R11in, bi.R10in,
                 bi.R9in, bi.R8in, bi.R7in, bi.R6in, bi.R5in, bi.R4in,
                 bi.R3in, bi.R2in, bi.R1in, bi.R0in};

  // Bus mux: walk from lowest to highest priority so the last hit (R0 side) wins
  always_comb begin
    busMux = '0;
    if (bi.Cout)      busMux = c_q;
    if (bi.InPortout) busMux = inport_q;
    if (bi.MDRout)    busMux = mdr_q;
    if (bi.PCout)     busMux = pc_q;
    if (bi.Zlowout)   busMux = zlo_q;
    if (bi.Zhighout)  busMux = zhi_q;
    if (bi.LOout)     busMux = lo_q;
    if (bi.HIout)     busMux = hi_q;
    for (int i = 15; i >= 0; i--) begin
      if (rOut[i]) busMux = r_q[i];
    end
  end

  assign shAmt  = busMux[4:0];
  assign rotAmt = 6'd32 - {1'b0, shAmt};

`ifdef BUS_MULDIV_EN
  logic signed [63:0] mulProd;
  logic signed [31:0] divA, divB, divQuo, divRem;

  assign divA    = y_q;
  assign divB    = busMux;
  assign mulProd = $signed({{32{y_q[31]}}, y_q}) * $signed({{32{busMux[31]}}, busMux});

  // Signed divide; zero divisor yields zero and the one overflowing case is pinned
  always_comb begin
    divQuo = '0;
    divRem = '0;
    if (divB == 32'sd0) begin
      divQuo = '0;
      divRem = '0;
    end else if (y_q == 32'h8000_0000 && busMux == 32'hFFFF_FFFF) begin
      divQuo = 32'sh8000_0000;
      divRem = '0;
    end else begin
      divQuo = divA / divB;
      divRem = divA % divB;
    end
  end
`endif

  // ALU: if/else chain makes the lowest set ALUControl bit win
  always_comb begin
    aluResult = '0;
    if (bi.ALUControl[0])       aluResult = {32'h0, y_q & busMux};
    else if (bi.ALUControl[1])  aluResult = {32'h0, y_q | busMux};
    else if (bi.ALUControl[2])  aluResult = {32'h0, y_q + busMux};
    else if (bi.ALUControl[3])  aluResult = {32'h0, y_q - busMux};
    else if (bi.ALUControl[4]) begin
`ifdef BUS_MULDIV_EN
      aluResult = mulProd;
`else
      aluResult = '0;
`endif
    end else if (bi.ALUControl[5]) begin
`ifdef BUS_MULDIV_EN
      aluResult = {divRem, divQuo};
`else
      aluResult = '0;
`endif
    end
    else if (bi.ALUControl[6])  aluResult = {32'h0, y_q >> shAmt};
    else if (bi.ALUControl[7])  aluResult = {32'h0, y_q << shAmt};
    else if (bi.ALUControl[8])  aluResult = {32'h0, (y_q >> shAmt) | (y_q << rotAmt)};
    else if (bi.ALUControl[9])  aluResult = {32'h0, (y_q << shAmt) | (y_q >> rotAmt)};
    else if (bi.ALUControl[10]) aluResult = {32'h0, 32'h0 - busMux};
    else if (bi.ALUControl[11]) aluResult = {32'h0, ~busMux};
  end

  assign mdr_d = bi.MDRRead ? bi.Mdatain : busMux;

  // General-purpose registers load the pre-edge bus value when enabled
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < 16; i++) r_q[i] <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (rIn[i]) r_q[i] <= busMux;
      end
    end
  end

  // Special registers; PC/InPort/C have no load path and simply hold zero
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      hi_q     <= '0;
      lo_q     <= '0;
      y_q      <= '0;
      mdr_q    <= '0;
      zhi_q    <= '0;
      zlo_q    <= '0;
      pc_q     <= '0;
      inport_q <= '0;
      c_q      <= '0;
    end else begin
      if (bi.HIin)  hi_q  <= busMux;
      if (bi.LOin)  lo_q  <= busMux;
      if (bi.Yin)   y_q   <= busMux;
      if (bi.MDRin) mdr_q <= mdr_d;
      if (bi.Zin) begin
        zhi_q <= aluResult[63:32];
        zlo_q <= aluResult[31:0];
      end
      pc_q     <= pc_q;
      inport_q <= inport_q;
      c_q      <= c_q;
    end
  end

  assign bi.BusMuxOut   = busMux;
  assign bi.R0MuxIn     = r_q[0];
  assign bi.R1MuxIn     = r_q[1];
  assign bi.R2MuxIn     = r_q[2];
  assign bi.R3MuxIn     = r_q[3];
  assign bi.R4MuxIn     = r_q[4];
  assign bi.R5MuxIn     = r_q[5];
  assign bi.R6MuxIn     = r_q[6];
  assign bi.R7MuxIn     = r_q[7];
  assign bi.R8MuxIn     = r_q[8];
  assign bi.R9MuxIn     = r_q[9];
  assign bi.R10MuxIn    = r_q[10];
  assign bi.R11MuxIn    = r_q[11];
  assign bi.R12MuxIn    = r_q[12];
  assign bi.R13MuxIn    = r_q[13];
  assign bi.R14MuxIn    = r_q[14];
  assign bi.R15MuxIn    = r_q[15];
  assign bi.HIMuxIn     = hi_q;
  assign bi.LOMuxIn     = lo_q;
  assign bi.ZhighMuxIn  = zhi_q;
  assign bi.ZlowMuxIn   = zlo_q;
  assign bi.PCMuxIn     = pc_q;
  assign bi.MDRMuxIn    = mdr_q;
  assign bi.InPortMuxIn = inport_q;
  assign bi.CMuxIn      = c_q;
  assign bi.Yout        = y_q;

endmodule

// File: tb/tb_bus.sv
// Bench for the bus datapath: directed scenarios followed by random traffic,
// all compared against an arithmetic model of the register state.
// Source bit order: 0..15 R0..R15, 16 HI, 17 LO, 18 Zhigh, 19 Zlow, 20 PC,
// 21 MDR, 22 InPort, 23 C. Load bit order: 0..15 R, 16 HI, 17 LO, 18 Z, 19 Y, 20 MDR.
module tb_bus;
  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  bus_if bi ();

  bus dut (
    .clk(clk),
    .clr(clr),
    .bi (bi)
  );

  logic [23:0] srcVec;
  logic [20:0] ldVec;
  logic [11:0] aluCtl;
  logic [31:0] memData;
  logic        mdrRead;

  assign bi.R0out = srcVec[0];   assign bi.R1out = srcVec[1];
  assign bi.R2out = srcVec[2];   assign bi.R3out = srcVec[3];
  assign bi.R4out = srcVec[4];   assign bi.R5out = srcVec[5];
  assign bi.R6out = srcVec[6];   assign bi.R7out = srcVec[7];
  assign bi.R8out = srcVec[8];   assign bi.R9out = srcVec[9];
  assign bi.R10out = srcVec[10]; assign bi.R11out = srcVec[11];
  assign bi.R12out = srcVec[12]; assign bi.R13out = srcVec[13];
  assign bi.R14out = srcVec[14]; assign bi.R15out = srcVec[15];
  assign bi.HIout = srcVec[16];  assign bi.LOout = srcVec[17];
  assign bi.Zhighout = srcVec[18]; assign bi.Zlowout = srcVec[19];
  assign bi.PCout = srcVec[20];  assign bi.MDRout = srcVec[21];
  assign bi.InPortout = srcVec[22]; assign bi.Cout = srcVec[23];
  assign bi.R0in = ldVec[0];   assign bi.R1in = ldVec[1];
  assign bi.R2in = ldVec[2];   assign bi.R3in = ldVec[3];
  assign bi.R4in = ldVec[4];   assign bi.R5in = ldVec[5];
  assign bi.R6in = ldVec[6];   assign bi.R7in = ldVec[7];
  assign bi.R8in = ldVec[8];   assign bi.R9in = ldVec[9];
  assign bi.R10in = ldVec[10]; assign bi.R11in = ldVec[11];
  assign bi.R12in = ldVec[12]; assign bi.R13in = ldVec[13];
  assign bi.R14in = ldVec[14]; assign bi.R15in = ldVec[15];
  assign bi.HIin = ldVec[16];  assign bi.LOin = ldVec[17];
  assign bi.Zin = ldVec[18];   assign bi.Yin = ldVec[19];
  assign bi.MDRin = ldVec[20];
  assign bi.ALUControl = aluCtl;
  assign bi.Mdatain = memData;
  assign bi.MDRRead = mdrRead;

  logic [31:0] regOut [16];
  assign regOut[0] = bi.R0MuxIn;   assign regOut[1] = bi.R1MuxIn;
  assign regOut[2] = bi.R2MuxIn;   assign regOut[3] = bi.R3MuxIn;
  assign regOut[4] = bi.R4MuxIn;   assign regOut[5] = bi.R5MuxIn;
  assign regOut[6] = bi.R6MuxIn;   assign regOut[7] = bi.R7MuxIn;
  assign regOut[8] = bi.R8MuxIn;   assign regOut[9] = bi.R9MuxIn;
  assign regOut[10] = bi.R10MuxIn; assign regOut[11] = bi.R11MuxIn;
  assign regOut[12] = bi.R12MuxIn; assign regOut[13] = bi.R13MuxIn;
  assign regOut[14] = bi.R14MuxIn; assign regOut[15] = bi.R15MuxIn;

  // Reference model state
  logic [31:0] mR [16];
  logic [31:0] mHi, mLo, mY, mMdr, mZh, mZl;

  int passCount = 0;
  int failCount = 0;
  int checkCount = 0;

  // Compare one observed value against the model and tally the outcome
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Value the bus should carry: first selected source in priority order
  function automatic logic [31:0] modelBus();
    logic [31:0] vals [24];
    logic [31:0] res;
    bit found;
    for (int i = 0; i < 16; i++) vals[i] = mR[i];
    vals[16] = mHi; vals[17] = mLo; vals[18] = mZh; vals[19] = mZl;
    vals[20] = 32'h0; vals[21] = mMdr; vals[22] = 32'h0; vals[23] = 32'h0;
    res = 32'h0;
    found = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (!found && srcVec[i]) begin
        res = vals[i];
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // ALU result computed with 64-bit integer arithmetic
  function automatic logic [63:0] modelAlu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [11:0] ctl);
    int op;
    longint sa, sb, q, r, p;
    logic [63:0] dbl, res;
    logic [31:0] lo32;
    int amt;
    op = -1;
    for (int i = 11; i >= 0; i--) if (ctl[i]) op = i;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    amt = int'(b[4:0]);
    dbl = {a, a};
    res = 64'h0;
    case (op)
      0: begin lo32 = a & b; res = {32'h0, lo32}; end
      1: begin lo32 = a | b; res = {32'h0, lo32}; end
      2: begin lo32 = a + b; res = {32'h0, lo32}; end
      3: begin lo32 = a - b; res = {32'h0, lo32}; end
`ifdef BUS_MULDIV_EN
      4: begin p = sa * sb; res = p; end
      5: begin
        if (b == 32'h0) res = 64'h0;
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
`endif
      6: begin lo32 = a >> amt; res = {32'h0, lo32}; end
      7: begin lo32 = a << amt; res = {32'h0, lo32}; end
      8: begin dbl = dbl >> amt; res = {32'h0, dbl[31:0]}; end
      9: begin dbl = dbl << amt; res = {32'h0, dbl[63:32]}; end
      10: begin lo32 = 32'h0 - b; res = {32'h0, lo32}; end
      11: begin lo32 = ~b; res = {32'h0, lo32}; end
      default: res = 64'h0;
    endcase
    return res;
  endfunction

  // Advance the model by one clock edge using pre-edge values
  task automatic modelClock();
    logic [31:0] busV;
    logic [63:0] aluV;
    busV = modelBus();
    aluV = modelAlu(mY, busV, aluCtl);
    for (int i = 0; i < 16; i++) if (ldVec[i]) mR[i] = busV;
    if (ldVec[16]) mHi = busV;
    if (ldVec[17]) mLo = busV;
    if (ldVec[18]) begin mZh = aluV[63:32]; mZl = aluV[31:0]; end
    if (ldVec[19]) mY = busV;
    if (ldVec[20]) mMdr = mdrRead ? memData : busV;
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) mR[i] = 32'h0;
    mHi = 0; mLo = 0; mY = 0; mMdr = 0; mZh = 0; mZl = 0;
  endtask

  task automatic applyStimulus(input logic [23:0] src, input logic [20:0] ld,
                               input logic [11:0] ctl, input logic [31:0] data,
                               input logic rd);
    srcVec = src; ldVec = ld; aluCtl = ctl; memData = data; mdrRead = rd;
  endtask

  // One clock edge with model update; leaves time at posedge + 1
  task automatic cycle();
    modelClock();
    @(posedge clk);
    #1;
  endtask

  // Put a value into a register via Mdatain -> MDR -> bus
  task automatic loadValue(input int ldBit, input logic [31:0] val);
    applyStimulus(24'h0, 21'h1 << 20, 12'h0, val, 1'b1);
    cycle();
    applyStimulus(24'h1 << 21, 21'h1 << ldBit, 12'h0, 32'h0, 1'b0);
    cycle();
  endtask

  task automatic checkAll(input string tag);
    for (int i = 0; i < 16; i++) checkOutput($sformatf("%s R%0d", tag, i), regOut[i], mR[i]);
    checkOutput({tag, " HI"}, bi.HIMuxIn, mHi);
    checkOutput({tag, " LO"}, bi.LOMuxIn, mLo);
    checkOutput({tag, " Zhigh"}, bi.ZhighMuxIn, mZh);
    checkOutput({tag, " Zlow"}, bi.ZlowMuxIn, mZl);
    checkOutput({tag, " Y"}, bi.Yout, mY);
    checkOutput({tag, " MDR"}, bi.MDRMuxIn, mMdr);
    checkOutput({tag, " PC"}, bi.PCMuxIn, 32'h0);
    checkOutput({tag, " InPort"}, bi.InPortMuxIn, 32'h0);
    checkOutput({tag, " C"}, bi.CMuxIn, 32'h0);
  endtask

  initial begin
    logic [23:0] src;
    logic [20:0] ld;
    logic [11:0] ctl;
    int sel;

    // Reset state
    clr = 1'b1;
    applyStimulus(24'h0, 21'h0, 12'h0, 32'h0, 1'b0);
    modelReset();
    #12;
    checkAll("reset");
    checkOutput("reset bus", bi.BusMuxOut, 32'h0);
    clr = 1'b0;
    @(posedge clk);
    #1;

    // Memory word through MDR into R2
    loadValue(2, 32'h22);
    checkOutput("mdr to R2", regOut[2], 32'h22);

    // NEG of R2 into Z, then Zlow into R5
    applyStimulus(24'h1 << 2, 21'h1 << 18, 12'h400, 32'h0, 1'b0);
    cycle();
    checkOutput("neg Zlow", bi.ZlowMuxIn, 32'hFFFF_FFDE);
    checkOutput("neg Zhigh", bi.ZhighMuxIn, 32'h0);
    applyStimulus(24'h1 << 19, 21'h1 << 5, 12'h0, 32'h0, 1'b0);
    cycle();
    checkOutput("Zlow to R5", regOut[5], 32'hFFFF_FFDE);

    // ADD / SUB with Y=5, bus=3
    loadValue(19, 32'd5);
    loadValue(3, 32'd3);
    applyStimulus(24'h1 << 3, 21'h1 << 18, 12'h004, 32'h0, 1'b0);
    cycle();
    checkOutput("add Zlow", bi.ZlowMuxIn, 32'd8);
    applyStimulus(24'h1 << 3, 21'h1 << 18, 12'h008, 32'h0, 1'b0);
    cycle();
    checkOutput("sub Zlow", bi.ZlowMuxIn, 32'd2);

    // Lowest set bit wins: ADD+SUB acts as ADD; no bit gives zero
    applyStimulus(24'h1 << 3, 21'h1 << 18, 12'h00C, 32'h0, 1'b0);
    cycle();
    checkOutput("multi-bit Zlow", bi.ZlowMuxIn, 32'd8);
    applyStimulus(24'h1 << 3, 21'h1 << 18, 12'h000, 32'h0, 1'b0);
    cycle();
    checkOutput("no-op Zlow", bi.ZlowMuxIn, 32'd0);

    // MUL / DIV, including divide by zero
    loadValue(19, 32'hFFFF_FFFF);
    loadValue(3, 32'd2);
    applyStimulus(24'h1 << 3, 21'h1 << 18, 12'h010, 32'h0, 1'b0);
    cycle();
`ifdef BUS_MULDIV_EN
    checkOutput("mul Zhigh", bi.ZhighMuxIn, 32'hFFFF_FFFF);
    checkOutput("mul Zlow", bi.ZlowMuxIn, 32'hFFFF_FFFE);
`else
    checkOutput("mul Zhigh", bi.ZhighMuxIn, 32'h0);
    checkOutput("mul Zlow", bi.ZlowMuxIn, 32'h0);
`endif
    loadValue(19, 32'd7);
    applyStimulus(24'h1 << 3, 21'h1 << 18, 12'h020, 32'h0, 1'b0);
    cycle();
`ifdef BUS_MULDIV_EN
    checkOutput("div Zlow", bi.ZlowMuxIn, 32'd3);
    checkOutput("div Zhigh", bi.ZhighMuxIn, 32'd1);
`else
    checkOutput("div Zlow", bi.ZlowMuxIn, 32'd0);
    checkOutput("div Zhigh", bi.ZhighMuxIn, 32'd0);
`endif
    applyStimulus(24'h0, 21'h1 << 18, 12'h020, 32'h0, 1'b0);
    cycle();
    checkOutput("div0 Zlow", bi.ZlowMuxIn, 32'd0);
    checkOutput("div0 Zhigh", bi.ZhighMuxIn, 32'd0);

    // Bus idle value and priority between two sources
    applyStimulus(24'h0, 21'h0, 12'h0, 32'h0, 1'b0);
    #1;
    checkOutput("idle bus", bi.BusMuxOut, 32'h0);
    loadValue(1, 32'hAAAA_5555);
    applyStimulus(24'h00000A, 21'h0, 12'h0, 32'h0, 1'b0);
    #1;
    checkOutput("R1 over R3", bi.BusMuxOut, 32'hAAAA_5555);
    cycle();

    // Random traffic against the model
    for (int iter = 0; iter < 200; iter++) begin
      src = '0;
      for (int k = 0; k < 24; k++) if ($urandom_range(0, 9) == 0) src[k] = 1'b1;
      if (iter % 10 == 0) src = '0;
      ld = '0;
      for (int k = 0; k < 21; k++) if ($urandom_range(0, 3) == 0) ld[k] = 1'b1;
      sel = int'($urandom_range(0, 3));
      if (sel == 0) ctl = 12'h0;
      else if (sel == 3) ctl = 12'($urandom);
      else ctl = 12'h1 << $urandom_range(0, 11);
      applyStimulus(src, ld, ctl, $urandom, 1'($urandom_range(0, 1)));
      #1;
      checkOutput($sformatf("rand%0d bus", iter), bi.BusMuxOut, modelBus());
      cycle();
      checkAll($sformatf("rand%0d", iter));
    end

    // Asynchronous clear between edges
    loadValue(4, 32'h1234);
    checkOutput("R4 before clr", regOut[4], 32'h1234);
    #2;
    clr = 1'b1;
    #1;
    modelReset();
    checkAll("async clr");
    clr = 1'b0;

    // Clear held across an edge overrides every load enable
    applyStimulus(24'h0, 21'h1FFFFF, 12'h004, 32'hFFFF_FFFF, 1'b1);
    clr = 1'b1;
    @(posedge clk);
    #1;
    checkAll("clr over load");
    clr = 1'b0;
    applyStimulus(24'h0, 21'h0, 12'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed no finish expected finish");
    $fatal(1, "[TB] timeout");
  end
endmodule
